dmem_arbiter: RTL and testbench

//  Two-requester round-robin arbiter in front of the 16x8 single-cycle data memory.

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a 16x8 single-cycle data memory.
// Grants are combinational; read data, read-valid and access counters are registered per requester.

module dmem_arbiter_port #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              gnt_i,
   input  logic              we_i,
   input  logic [DATA_W-1:0] rd_i,
   output logic              rvalid_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic [CNT_W-1:0]  cnt_o
);

   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      rvalid_d = gnt_i & ~we_i;
      rdata_d  = rvalid_d ? rd_i : rdata_q;
      cnt_d    = cnt_q;
      // saturate rather than wrap so long runs stay visibly pegged
      if (gnt_i && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         cnt_q    <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign cnt_o    = cnt_q;

endmodule

module dmem_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_read_select,
   output logic [ADDR_W-1:0] mem_write_select,
   output logic [DATA_W-1:0] mem_inp,
   output logic              mem_write_en,
   input  logic [DATA_W-1:0] mem_data_read,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);

   localparam int NUM_REQ = 2;

   logic [NUM_REQ-1:0]             req, we, gnt, rvalid;
   logic [NUM_REQ-1:0][ADDR_W-1:0] addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] wdata, rdata;
   logic [NUM_REQ-1:0][CNT_W-1:0]  cnt;
   logic                           last_gnt_q, last_gnt_d;
   logic                           sel, any_gnt;

   assign req   = {req1, req0};
   assign we    = {we1, we0};
   assign addr  = {addr1, addr0};
   assign wdata = {wdata1, wdata0};

   // grants are masked during reset so an in-flight write never reaches memory
   always_comb begin
      gnt = '0;
      if (!reset) begin
         if (&req)
            gnt = last_gnt_q ? 2'b01 : 2'b10;
         else
            gnt = req;
      end
   end

   assign any_gnt    = |gnt;
   assign sel        = gnt[1];
   assign last_gnt_d = any_gnt ? sel : last_gnt_q;

   assign mem_read_select  = any_gnt ? addr[sel]  : '0;
   assign mem_write_select = any_gnt ? addr[sel]  : '0;
   assign mem_inp          = any_gnt ? wdata[sel] : '0;
   assign mem_write_en     = any_gnt & we[sel];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) last_gnt_q <= 1'b1;
      else       last_gnt_q <= last_gnt_d;
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
      dmem_arbiter_port #(
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_port (
         .clock    (clock),
         .reset    (reset),
         .gnt_i    (gnt[i]),
         .we_i     (we[i]),
         .rd_i     (mem_data_read),
         .rvalid_o (rvalid[i]),
         .rdata_o  (rdata[i]),
         .cnt_o    (cnt[i])
      );
   end

   assign gnt0    = gnt[0];
   assign gnt1    = gnt[1];
   assign rvalid0 = rvalid[0];
   assign rvalid1 = rvalid[1];
   assign rdata0  = rdata[0];
   assign rdata1  = rdata[1];
   assign cnt0    = cnt[0];
   assign cnt1    = cnt[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 16x8 memory holding a fixed power-up image.

module tb_dmem_arbiter;

   localparam logic [7:0] IMAGE [16] = '{
      8'h07, 8'h03, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
      8'h19, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

   logic       clock = 1'b0;
   logic       reset, mem_init;
   logic       req0, req1, we0, we1;
   logic [3:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1, mem_write_en;
   logic [7:0] rdata0, rdata1, mem_inp, mem_data_read, cnt0, cnt1;
   logic [3:0] mem_read_select, mem_write_select;
   logic [7:0] mem [16];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem_init)          mem <= IMAGE;
      else if (mem_write_en) mem[mem_write_select] <= mem_inp;
   end
   assign mem_data_read = mem[mem_read_select];

   dmem_arbiter dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_read_select(mem_read_select), .mem_write_select(mem_write_select),
      .mem_inp(mem_inp), .mem_write_en(mem_write_en), .mem_data_read(mem_data_read),
      .cnt0(cnt0), .cnt1(cnt1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      step();
      reset = 0;
   endtask

   initial begin
      bit ok;
      idle_inputs();
      reset = 1; mem_init = 1;
      step();
      mem_init = 0;
      step();
      chk("rst_gnt", {gnt1, gnt0}, 2'b00);
      chk("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
      chk("rst_rdata", {rdata1, rdata0}, 16'h0000);
      chk("rst_cnt", {cnt1, cnt0}, 16'h0000);
      chk("rst_mem_we", mem_write_en, 1'b0);
      reset = 0;
      step();

      // 1: single read of addr 0
      req0 = 1; addr0 = 0;
      #1 chk("t1_gnt", {gnt1, gnt0}, 2'b01);
      chk("t1_mem_we", mem_write_en, 1'b0);
      step();
      idle_inputs();
      chk("t1_rvalid", rvalid0, 1'b1);
      chk("t1_rdata", rdata0, 8'h07);
      chk("t1_cnt", cnt0, 8'd1);
      step();
      chk("t1_rvalid_pulse", rvalid0, 1'b0);
      chk("t1_rdata_hold", rdata0, 8'h07);

      // 2: contention, alternating grants starting with requester 0
      do_reset();
      req0 = 1; addr0 = 1; req1 = 1; addr1 = 8;
      for (int k = 0; k < 4; k++) begin
         #1 chk($sformatf("t2_gnt%0d", k), {gnt1, gnt0}, (k % 2 == 0) ? 2'b01 : 2'b10);
         chk($sformatf("t2_rsel%0d", k), mem_read_select, (k % 2 == 0) ? 4'd1 : 4'd8);
         step();
      end
      idle_inputs();
      chk("t2_rdata0", rdata0, 8'h03);
      chk("t2_rdata1", rdata1, 8'h19);
      chk("t2_cnt", {cnt1, cnt0}, 16'h0202);

      // 3: write by requester 1 then read-back by requester 0
      req1 = 1; we1 = 1; addr1 = 3; wdata1 = 8'h5A;
      #1 chk("t3_gnt", {gnt1, gnt0}, 2'b10);
      chk("t3_we", mem_write_en, 1'b1);
      chk("t3_wsel", mem_write_select, 4'd3);
      chk("t3_inp", mem_inp, 8'h5A);
      step();
      idle_inputs();
      req0 = 1; addr0 = 3;
      #1 chk("t3_gnt_rd", {gnt1, gnt0}, 2'b01);
      chk("t3_we_rd", mem_write_en, 1'b0);
      chk("t3_no_rvalid_wr", rvalid1, 1'b0);
      step();
      idle_inputs();
      chk("t3_rvalid", rvalid0, 1'b1);
      chk("t3_rdata", rdata0, 8'h5A);
      chk("t3_we_after", mem_write_en, 1'b0);

      // 4: requester 0 streams 300 reads; counter saturates
      do_reset();
      req0 = 1; addr0 = 0;
      ok = 1;
      for (int k = 0; k < 300; k++) begin
         #1 if (!(gnt0 === 1'b1 && gnt1 === 1'b0)) ok = 0;
         if (k == 254) chk("t4_cnt_fe", cnt0, 8'hFE);
         if (k == 256) chk("t4_cnt_sat", cnt0, 8'hFF);
         step();
      end
      idle_inputs();
      chk("t4_gnt_all", ok, 1'b1);
      chk("t4_cnt0", cnt0, 8'hFF);
      chk("t4_cnt1", cnt1, 8'h00);

      // 5: reset lands during a granted write
      req0 = 1; we0 = 1; addr0 = 2; wdata0 = 8'hFF;
      #1 chk("t5_we_pre", mem_write_en, 1'b1);
      #1 reset = 1;
      #1 chk("t5_we_rst", mem_write_en, 1'b0);
      chk("t5_gnt_rst", {gnt1, gnt0}, 2'b00);
      chk("t5_rst_outs", {rvalid1, rvalid0, rdata1, rdata0, cnt1, cnt0}, 34'h0);
      step();
      idle_inputs();
      step();
      reset = 0;
      req0 = 1; addr0 = 2; req1 = 1; addr1 = 8;
      #1 chk("t5_first_gnt", {gnt1, gnt0}, 2'b01);
      step();
      chk("t5_addr2_kept", rdata0, 8'h02);
      chk("t5_second_gnt", {gnt1, gnt0}, 2'b10);
      step();
      idle_inputs();
      chk("t5_rvalid1", rvalid1, 1'b1);
      chk("t5_rdata1", rdata1, 8'h19);
      step();

      // 6: idle cycles leave everything quiet
      ok = 1;
      for (int k = 0; k < 10; k++) begin
         #1 if (gnt0 || gnt1 || mem_write_en || rvalid0 || rvalid1) ok = 0;
         step();
      end
      chk("t6_quiet", ok, 1'b1);
      chk("t6_cnt", {cnt1, cnt0}, 16'h0101);
      chk("t6_mux_zero", {mem_read_select, mem_write_select, mem_inp}, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
